enigma_core_n: RTL and testbench
================================

ENIGMA_CORE_N -- requirements
Module: enigma_core_n

Interface
REQ-001 Parameter LETTERS, default 26, alphabet size; symbols encoded 1..LETTERS, 0 = none/invalid.
REQ-002 Parameter NROT, default 3, rotor count (2..8); index 1 = fast rotor.
REQ-003 Parameter SYMB_W, default 7, symbol/position width.
REQ-004 clk_i  input  1  clock; all state on its rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 cfg_load_i  input  1  load rotor start positions from cfg_pos_i.
REQ-007 cfg_pos_i  input  [NROT][SYMB_W]  start positions, 1..LETTERS.
REQ-008 in_symb_i  input  SYMB_W  plaintext symbol.
REQ-009 in_valid_i  input  1  in_symb_i valid.
REQ-010 in_ready_o  output  1  core accepts a symbol this cycle.
REQ-011 out_symb_o  output  SYMB_W  ciphertext symbol.
REQ-012 out_err_o  output  1  symbol was out of range, out_symb_o = 0.
REQ-013 out_valid_o  output  1  out_symb_o/out_err_o valid.
REQ-014 out_ready_i  input  1  downstream accepts output.
REQ-015 pos_o  output  [NROT][SYMB_W]  current rotor positions.

Function
REQ-016 Accept when in_valid_i && in_ready_o; in_ready_o = !out_valid_o || out_ready_i (global pipeline enable).
REQ-017 Stall (enable low) freezes every pipeline stage, out_symb_o/out_valid_o held stable.
REQ-018 On accept of a valid symbol, rotors step before encryption; encryption uses post-step positions.
REQ-019 Stepping: rotor 1 always steps; rotor k>1 steps if rotor k-1 at NOTCH[k-1]; rotor k in 2..NROT-1 also steps if itself at NOTCH[k] (double-step); rotor NROT never double-steps.
REQ-020 Position wrap: LETTERS -> 1.
REQ-021 Symbol outside 1..LETTERS: no stepping, flows through pipeline with error flag, emerges with out_symb_o = 0, out_err_o = 1.
REQ-022 Rotor k forward: y = wrap(F_k[wrap(x + p_k - 1)] - (p_k - 1)); backward same with B_k; wrap() maps into 1..LETTERS.
REQ-023 Path: rotors 1..NROT forward, reflector R, rotors NROT..1 backward.
REQ-024 Positions snapshot per accepted symbol travels with it; later stepping/loads never affect in-flight symbols.
REQ-025 Pipeline: input register, one stage per rotor pass, one reflector stage, output register; latency 2*NROT+2 enabled cycles (8 at NROT=3).
REQ-026 Full throughput: one symbol per cycle with out_ready_i held high.
REQ-027 cfg_load_i sets positions to cfg_pos_i; same-cycle accept steps from the loaded values.
REQ-028 cfg_pos_i entry outside 1..LETTERS loads as 1.
REQ-029 Arithmetic signed, SYMB_W+1 bits internally; no truncation before wrap.

Reset
REQ-030 rst_i clears all pipeline valid/error flags and data to 0; out_valid_o = 0, out_symb_o = 0, out_err_o = 0.
REQ-031 rst_i sets all positions to 1; pos_o reads 1 for every rotor.
REQ-032 Reset mid-operation discards all in-flight symbols; no output produced for them.
REQ-033 in_ready_o = 1 in reset deassertion cycle onward.

Structure
REQ-034 Package enigma_pkg holds LETTERS default, rotor forward/backward tables, notch table, reflector table, wrap function.
REQ-035 Default tables: rotor 1 = III, 2 = II, 3 = I (Enigma I), reflector B; notches V, E, Q.
REQ-036 One sub-module enigma_rotor_stage (single table lookup with offset, registered, enable), instantiated 2*NROT times.

Verification
REQ-037 Positions AAA, input AAAAA -> output BDZGO; pos_o after = A,A,F (slow..fast).
REQ-038 Load ADU, three symbols -> positions ADV, AEW, BFX (double-step).
REQ-039 Input 0 and 27 between valid symbols -> out_err_o = 1, out_symb_o = 0, positions unchanged.
REQ-040 Stream 20 symbols, out_ready_i low 5 cycles mid-stream -> no loss/duplication, order preserved, latency 8 enabled cycles.
REQ-041 Encrypt HELLO at AAA, reload AAA, encrypt result -> HELLO.
REQ-042 Assert rst_i with 4 symbols in flight -> out_valid_o low, positions 1, no stale output after release.

Source files
------------

// File: rtl/enigma_pkg.sv
// -----------------------------------------------------------------------------
// enigma_pkg
// Shared constants and helpers for the Enigma cipher core:
//   - LETTERS            default alphabet size
//   - ROT_TAB / NOTCH    rotor wirings and turnover positions, by slot
//                        (slot 0 = III, 1 = II, 2 = I; rotor k uses slot (k-1)%3)
//   - REFL_TAB           reflector B
//   - wrap()             fold a value back into 1..n
//   - rotor_fwd/bwd()    forward / inverse rotor wiring lookup
//   - reflect()          reflector lookup
// Tables are ASCII strings; symbol value = letter - 'A' + 1.
// -----------------------------------------------------------------------------
package enigma_pkg;

   localparam int LETTERS = 26;
   localparam int NTAB    = 3;
   localparam int TAB_W   = 8 * LETTERS;

   typedef logic [TAB_W-1:0] tab_t;

   localparam tab_t ROT_TAB [NTAB] = '{
      "BDFHJLCPRTXVZNYEIWGAKMUSQO",   // III (fast rotor)
      "AJDKSIRUXBLHWTMCQGZNPYFVOE",   // II
      "EKMFLGDQVZNTOWYHXUSPAIBRCJ"    // I
   };
   localparam tab_t REFL_TAB = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
   // Turnover letters V, E, Q for slots III, II, I.
   localparam int NOTCH [NTAB] = '{22, 5, 17};

   // Single correction is enough: every caller stays within 1-n .. 2n.
   function automatic int wrap(int v, int n);
      int r;
      r = v;
      if (v < 1)      r = v + n;
      else if (v > n) r = v - n;
      return r;
   endfunction

   // Leftmost character of the string is entry 1; out-of-range index gives 0.
   function automatic int tab_at(tab_t t, int x);
      int r;
      r = 0;
      if (x >= 1 && x <= LETTERS) r = int'(t[(LETTERS-x)*8 +: 8]) - 64;
      return r;
   endfunction

   function automatic int slot_of(int k);
      return (k - 1) % NTAB;
   endfunction

   function automatic int notch_of(int k);
      return NOTCH[slot_of(k)];
   endfunction

   function automatic int rotor_fwd(int slot, int x);
      return tab_at(ROT_TAB[slot], x);
   endfunction

   function automatic int rotor_bwd(int slot, int y);
      int r;
      r = 0;
      for (int j = 1; j <= LETTERS; j++) begin
         if (tab_at(ROT_TAB[slot], j) == y) r = j;
      end
      return r;
   endfunction

   function automatic int reflect(int x);
      return tab_at(REFL_TAB, x);
   endfunction

endpackage

// File: rtl/enigma_core_n_if.sv
// -----------------------------------------------------------------------------
// enigma_core_n_if
// Bus bundle for enigma_core_n: rotor configuration, input symbol stream,
// output symbol stream and rotor position readback.
//   cfg_load_i/cfg_pos_i      load start positions (index 0 = fast rotor)
//   in_symb_i/in_valid_i/in_ready_o     plaintext stream
//   out_symb_o/out_err_o/out_valid_o/out_ready_i  ciphertext stream
//   pos_o                     current rotor positions
// slave = the core, master = the driver of the core.
// -----------------------------------------------------------------------------
interface enigma_core_n_if #(
   parameter int NROT   = 3,
   parameter int SYMB_W = 7
);
   logic                         cfg_load_i;
   logic [NROT-1:0][SYMB_W-1:0]  cfg_pos_i;
   logic [SYMB_W-1:0]            in_symb_i;
   logic                         in_valid_i;
   logic                         in_ready_o;
   logic [SYMB_W-1:0]            out_symb_o;
   logic                         out_err_o;
   logic                         out_valid_o;
   logic                         out_ready_i;
   logic [NROT-1:0][SYMB_W-1:0]  pos_o;

   modport slave (
      input  cfg_load_i, cfg_pos_i, in_symb_i, in_valid_i, out_ready_i,
      output in_ready_o, out_symb_o, out_err_o, out_valid_o, pos_o
   );

   modport master (
      output cfg_load_i, cfg_pos_i, in_symb_i, in_valid_i, out_ready_i,
      input  in_ready_o, out_symb_o, out_err_o, out_valid_o, pos_o
   );
endinterface

// File: rtl/enigma_rotor_stage.sv
// -----------------------------------------------------------------------------
// enigma_rotor_stage
// One registered rotor pass: y = wrap(T[wrap(x + p - 1)] - (p - 1)), with T
// the forward wiring (BWD=0) or its inverse (BWD=1) of table slot SLOT.
//   clk_i, rst_i   clock, async active-high reset (clears y_o)
//   en_i           pipeline enable; register holds when low
//   x_i            incoming symbol 1..LETTERS
//   p_i            rotor position snapshot for this symbol, 1..LETTERS
//   y_o            registered outgoing symbol
// -----------------------------------------------------------------------------
module enigma_rotor_stage #(
   parameter int   SYMB_W  = 7,
   parameter int   LETTERS = 26,
   parameter bit   BWD     = 1'b0,
   parameter int   SLOT    = 0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              en_i,
   input  logic [SYMB_W-1:0] x_i,
   input  logic [SYMB_W-1:0] p_i,
   output logic [SYMB_W-1:0] y_o
);
   import enigma_pkg::*;

   // One extra bit keeps x+p-1 and T-(p-1) exact before folding.
   logic signed [SYMB_W:0] off, idx_raw, y_raw;
   int                     idx, t;
   logic [SYMB_W-1:0]      y_d, y_q;

   always_comb begin
      off     = $signed({1'b0, p_i}) - (SYMB_W+1)'(1);
      idx_raw = $signed({1'b0, x_i}) + off;
      idx     = wrap(int'(idx_raw), LETTERS);
      t       = BWD ? rotor_bwd(SLOT, idx) : rotor_fwd(SLOT, idx);
      y_raw   = (SYMB_W+1)'(t) - off;
      y_d     = SYMB_W'(wrap(int'(y_raw), LETTERS));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)     y_q <= '0;
      else if (en_i) y_q <= y_d;
   end

   assign y_o = y_q;

endmodule

// File: rtl/enigma_core_n.sv
// -----------------------------------------------------------------------------
// enigma_core_n
// Pipelined N-rotor Enigma cipher core.
//   clk_i   clock, all state on rising edge
//   rst_i   asynchronous active-high reset
//   bus     enigma_core_n_if.slave (config, input stream, output stream,
//           position readback)
// Pipeline: input register, NROT forward rotor stages, reflector stage,
// NROT backward rotor stages, output register. One global enable
// (!out_valid || out_ready) moves every stage together. Each symbol carries
// its own post-step rotor positions down per-rotor delay lines, so stepping
// or reloads after acceptance never touch it. Out-of-range symbols travel
// with an error flag, do not step rotors and leave as symbol 0.
// -----------------------------------------------------------------------------
module enigma_core_n #(
   parameter int LETTERS = 26,
   parameter int NROT    = 3,
   parameter int SYMB_W  = 7
) (
   input  logic               clk_i,
   input  logic               rst_i,
   enigma_core_n_if.slave     bus
);
   import enigma_pkg::*;

   localparam int STAGES = 2*NROT + 2;   // index of the output register

   typedef logic [SYMB_W-1:0] sym_t;

   logic                        en, accept, sym_ok;
   logic [NROT-1:0][SYMB_W-1:0] pos_q, pos_d, base;
   logic [NROT-1:0]             step;
   logic [STAGES:0]             vld_pipe_q, err_pipe_q;
   sym_t                        sym_s [0:2*NROT+1];
   sym_t                        in_sym_q, refl_q, out_symb_q;

   assign en     = !vld_pipe_q[STAGES] || bus.out_ready_i;
   assign accept = bus.in_valid_i && en;
   assign sym_ok = (bus.in_symb_i != '0) && (int'(bus.in_symb_i) <= LETTERS);

   // Stepping works on the loaded positions when cfg_load_i is high, so a
   // same-cycle accept steps from the freshly loaded values.
   always_comb begin
      base = pos_q;
      if (bus.cfg_load_i) begin
         for (int k = 0; k < NROT; k++) begin
            base[k] = (bus.cfg_pos_i[k] != '0 && int'(bus.cfg_pos_i[k]) <= LETTERS)
                      ? bus.cfg_pos_i[k] : sym_t'(1);
         end
      end
      // step[k] is rotor k+1: stepped by the rotor below sitting on its notch,
      // or (middle rotors only) by sitting on its own notch.
      step    = '0;
      step[0] = 1'b1;
      for (int k = 1; k < NROT; k++) begin
         step[k] = (base[k-1] == sym_t'(notch_of(k))) ||
                   ((k < NROT-1) && (base[k] == sym_t'(notch_of(k+1))));
      end
      pos_d = base;
      if (accept && sym_ok) begin
         for (int k = 0; k < NROT; k++) begin
            if (step[k]) pos_d[k] = (base[k] == sym_t'(LETTERS)) ? sym_t'(1) : base[k] + sym_t'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pos_q      <= {NROT{sym_t'(1)}};
         vld_pipe_q <= '0;
         err_pipe_q <= '0;
         in_sym_q   <= '0;
         refl_q     <= '0;
         out_symb_q <= '0;
      end else begin
         pos_q <= pos_d;
         if (en) begin
            vld_pipe_q <= {vld_pipe_q[STAGES-1:0], accept};
            err_pipe_q <= {err_pipe_q[STAGES-1:0], accept && !sym_ok};
            in_sym_q   <= (accept && sym_ok) ? bus.in_symb_i : '0;
            refl_q     <= sym_t'(reflect(int'(sym_s[NROT])));
            out_symb_q <= (err_pipe_q[STAGES-1] || !vld_pipe_q[STAGES-1]) ? '0 : sym_s[2*NROT+1];
         end
      end
   end

   assign sym_s[0]      = in_sym_q;
   assign sym_s[NROT+1] = refl_q;

   for (genvar k = 1; k <= NROT; k++) begin : g_rot
      // Rotor k's backward pass is stage 2*NROT+2-k, reading stage LAST.
      localparam int LAST = 2*NROT + 1 - k;
      sym_t pdly_q [0:LAST];

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            for (int j = 0; j <= LAST; j++) pdly_q[j] <= '0;
         end else if (en) begin
            pdly_q[0] <= pos_d[k-1];
            for (int j = 1; j <= LAST; j++) pdly_q[j] <= pdly_q[j-1];
         end
      end

      enigma_rotor_stage #(
         .SYMB_W(SYMB_W), .LETTERS(LETTERS), .BWD(1'b0), .SLOT(slot_of(k))
      ) u_fwd (
         .clk_i(clk_i), .rst_i(rst_i), .en_i(en),
         .x_i(sym_s[k-1]), .p_i(pdly_q[k-1]), .y_o(sym_s[k])
      );

      enigma_rotor_stage #(
         .SYMB_W(SYMB_W), .LETTERS(LETTERS), .BWD(1'b1), .SLOT(slot_of(k))
      ) u_bwd (
         .clk_i(clk_i), .rst_i(rst_i), .en_i(en),
         .x_i(sym_s[LAST]), .p_i(pdly_q[LAST]), .y_o(sym_s[LAST+1])
      );
   end

   assign bus.in_ready_o  = en;
   assign bus.out_symb_o  = out_symb_q;
   assign bus.out_err_o   = err_pipe_q[STAGES];
   assign bus.out_valid_o = vld_pipe_q[STAGES];
   assign bus.pos_o       = pos_q;

endmodule

// File: tb/tb_enigma_core_n.sv
// -----------------------------------------------------------------------------
// tb_enigma_core_n
// Drives enigma_core_n through its interface and compares every output and
// the rotor positions against a letter-level Enigma model (string tables,
// modulo-26 arithmetic) plus a queue scoreboard carrying the expected
// symbol, error flag and arrival time (in enabled clock edges).
// -----------------------------------------------------------------------------
module tb_enigma_core_n;

   localparam int NR  = 3;
   localparam int W   = 7;
   localparam int L   = 26;
   localparam int LAT = 2*NR + 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   enigma_core_n_if #(.NROT(NR), .SYMB_W(W)) bus ();

   enigma_core_n #(.LETTERS(L), .NROT(NR), .SYMB_W(W)) dut (
      .clk_i(clk), .rst_i(rst), .bus(bus)
   );

   // Model tables, index 0 = fast rotor (III), then II, then I.
   string ROT [NR] = '{"BDFHJLCPRTXVZNYEIWGAKMUSQO",
                       "AJDKSIRUXBLHWTMCQGZNPYFVOE",
                       "EKMFLGDQVZNTOWYHXUSPAIBRCJ"};
   string REFL     = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
   int    NOTCHL [NR] = '{22, 5, 17};

   int mpos [NR];
   int exp_sym[$], exp_err[$], exp_tag[$];
   int got[$], got_err[$];
   int n_chk = 0, n_fail = 0, en_cnt = 0;
   bit last_acc;

   task automatic chk(input string tag, input int got_v, input int exp_v);
      n_chk++;
      if (got_v != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got_v, exp_v);
      end
   endtask

   // Letter-level Enigma: 0-based letters, positions 1-based.
   function automatic int mdl_enc(int s);
      int c, t;
      c = s - 1;
      for (int k = 0; k < NR; k++)
         c = (ROT[k][(c + mpos[k] - 1) % L] - 65 - (mpos[k] - 1) + L) % L;
      c = REFL[c] - 65;
      for (int k = NR-1; k >= 0; k--) begin
         t = (c + mpos[k] - 1) % L;
         for (int j = 0; j < L; j++)
            if (ROT[k][j] - 65 == t) c = (j - (mpos[k] - 1) + L) % L;
      end
      return c + 1;
   endfunction

   task automatic mdl_step();
      bit st [NR];
      st[0] = 1'b1;
      for (int k = 1; k < NR; k++)
         st[k] = (mpos[k-1] == NOTCHL[k-1]) || (k < NR-1 && mpos[k] == NOTCHL[k]);
      for (int k = 0; k < NR; k++)
         if (st[k]) mpos[k] = mpos[k] % L + 1;
   endtask

   function automatic int posv();
      return int'(bus.pos_o[2])*10000 + int'(bus.pos_o[1])*100 + int'(bus.pos_o[0]);
   endfunction

   // One clock: drive at negedge, check 1ns later, update model, take edge.
   task automatic cyc(input bit vld, input int sym, input bit ordy,
                      input bit load, input int ps, input int pm, input int pf);
      bit en;
      int cfg [NR];
      bus.in_valid_i   = vld;
      bus.in_symb_i    = W'(sym);
      bus.out_ready_i  = ordy;
      bus.cfg_load_i   = load;
      bus.cfg_pos_i[2] = W'(ps);
      bus.cfg_pos_i[1] = W'(pm);
      bus.cfg_pos_i[0] = W'(pf);
      #1;
      for (int k = 0; k < NR; k++) chk("pos_o", int'(bus.pos_o[k]), mpos[k]);
      if (bus.out_valid_o) begin
         if (exp_sym.size() == 0) chk("spurious_out", 1, 0);
         else begin
            chk("out_symb", int'(bus.out_symb_o), exp_sym[0]);
            chk("out_err", int'(bus.out_err_o), exp_err[0]);
            chk("latency", en_cnt, exp_tag[0]);
            if (ordy) begin
               got.push_back(int'(bus.out_symb_o));
               got_err.push_back(int'(bus.out_err_o));
               void'(exp_sym.pop_front());
               void'(exp_err.pop_front());
               void'(exp_tag.pop_front());
            end
         end
      end
      last_acc = vld && bus.in_ready_o;
      cfg = '{pf, pm, ps};
      if (load)
         for (int k = 0; k < NR; k++) mpos[k] = (cfg[k] >= 1 && cfg[k] <= L) ? cfg[k] : 1;
      if (last_acc) begin
         if (sym >= 1 && sym <= L) begin
            mdl_step();
            exp_sym.push_back(mdl_enc(sym));
            exp_err.push_back(0);
         end else begin
            exp_sym.push_back(0);
            exp_err.push_back(1);
         end
         // Accept edge loads the input register; LAT more enabled edges to output.
         exp_tag.push_back(en_cnt + 1 + LAT);
      end
      en = bus.in_ready_o;
      @(posedge clk);
      if (en) en_cnt++;
      @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && exp_sym.size() > 0; i++) cyc(0, 0, 1, 0, 1, 1, 1);
      chk("drain_left", exp_sym.size(), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.in_valid_i = 1'b0; bus.cfg_load_i = 1'b0; bus.out_ready_i = 1'b1;
      #1;
      chk("rst_out_valid", int'(bus.out_valid_o), 0);
      chk("rst_out_symb", int'(bus.out_symb_o), 0);
      chk("rst_out_err", int'(bus.out_err_o), 0);
      for (int k = 0; k < NR; k++) chk("rst_pos", int'(bus.pos_o[k]), 1);
      exp_sym.delete(); exp_err.delete(); exp_tag.delete();
      for (int k = 0; k < NR; k++) mpos[k] = 1;
      repeat (2) begin @(posedge clk); @(negedge clk); end
      rst = 1'b0;
      #1;
      chk("ready_after_rst", int'(bus.in_ready_o), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      string s_ref;
      int    ct [5];
      int    stream [20];
      int    i, c, r, sym;

      rst = 1'b0;
      bus.in_valid_i = 1'b0; bus.in_symb_i = '0; bus.cfg_load_i = 1'b0;
      bus.cfg_pos_i = '0; bus.out_ready_i = 1'b1;
      #2;
      do_reset();

      // AAA, AAAAA -> BDZGO, rotors end at A,A,F
      cyc(0, 0, 1, 1, 1, 1, 1);
      got.delete(); got_err.delete();
      repeat (5) cyc(1, 1, 1, 0, 1, 1, 1);
      drain();
      s_ref = "BDZGO";
      chk("aaaaa_count", got.size(), 5);
      for (int k = 0; k < 5 && k < got.size(); k++) chk("aaaaa_out", got[k], s_ref[k] - 64);
      chk("aaf_slow", int'(bus.pos_o[2]), 1);
      chk("aaf_mid", int'(bus.pos_o[1]), 1);
      chk("aaf_fast", int'(bus.pos_o[0]), 6);

      // Load ADU: double step ADV, AEW, BFX
      cyc(0, 0, 1, 1, 1, 4, 21);
      cyc(1, 7, 1, 0, 1, 1, 1);  chk("pos_adv", posv(), 10422);
      cyc(1, 7, 1, 0, 1, 1, 1);  chk("pos_aew", posv(), 10523);
      cyc(1, 7, 1, 0, 1, 1, 1);  chk("pos_bfx", posv(), 20624);
      drain();

      // Out-of-range symbols between valid ones
      got.delete(); got_err.delete();
      cyc(1, 1, 1, 0, 1, 1, 1);
      cyc(1, 0, 1, 0, 1, 1, 1);
      cyc(1, 27, 1, 0, 1, 1, 1);
      cyc(1, 1, 1, 0, 1, 1, 1);
      drain();
      if (got.size() == 4) begin
         chk("err0_flag", got_err[1], 1);  chk("err0_symb", got[1], 0);
         chk("err27_flag", got_err[2], 1); chk("err27_symb", got[2], 0);
         chk("ok_flag", got_err[3], 0);
      end else chk("err_count", got.size(), 4);

      // 20-symbol stream with a 5-cycle downstream stall
      for (int k = 0; k < 20; k++) stream[k] = $urandom_range(1, L);
      got.delete(); got_err.delete();
      i = 0; c = 0;
      while (i < 20 && c < 200) begin
         cyc(1, stream[i], (c < 10 || c >= 15), 0, 1, 1, 1);
         if (last_acc) i++;
         c++;
      end
      chk("stream_accepted", i, 20);
      drain();
      chk("stream_count", got.size(), 20);

      // HELLO round trip
      s_ref = "HELLO";
      cyc(0, 0, 1, 1, 1, 1, 1);
      got.delete(); got_err.delete();
      for (int k = 0; k < 5; k++) cyc(1, s_ref[k] - 64, 1, 0, 1, 1, 1);
      drain();
      for (int k = 0; k < 5; k++) ct[k] = (k < got.size()) ? got[k] : 0;
      cyc(0, 0, 1, 1, 1, 1, 1);
      got.delete(); got_err.delete();
      for (int k = 0; k < 5; k++) cyc(1, ct[k], 1, 0, 1, 1, 1);
      drain();
      chk("hello_count", got.size(), 5);
      for (int k = 0; k < 5 && k < got.size(); k++) chk("hello_out", got[k], s_ref[k] - 64);

      // Reset with 4 symbols in flight, then no stale output
      for (int k = 0; k < 4; k++) cyc(1, $urandom_range(1, L), 1, 0, 1, 1, 1);
      do_reset();
      got.delete();
      repeat (12) cyc(0, 0, 1, 0, 1, 1, 1);
      chk("no_stale_out", got.size(), 0);

      // Random traffic with backpressure, bad symbols and reloads
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 9);
         sym = (r == 0) ? (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(27, 127))
                        : $urandom_range(1, L);
         cyc(($urandom_range(0, 9) < 7), sym, ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 31) == 0),
             $urandom_range(0, 30), $urandom_range(0, 30), $urandom_range(0, 30));
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
